// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit
//
// Instruction fetch stage placed directly in front of the instruction cache.
// It owns the program counter and keeps a single aligned fetch outstanding
// at a time. Returned instructions are stored with their PC in a small FIFO
// that feeds decode. It also handles control-flow redirects, including a
// redirect that arrives while a cache miss is still in flight.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   icache_req_valid    fetch request to the I-cache
//   icache_req_addr     word-aligned fetch address (always the current pc)
//   icache_req_ready    I-cache is idle and can start a new lookup
//   icache_resp_valid   same-cycle hit / data valid for icache_req_addr
//   icache_resp_data    instruction word returned by the I-cache
//   redirect_valid      branch/jump/trap redirect request
//   redirect_pc         redirect target (bits [1:0] are ignored)
//   if_valid            head of the fetch queue is valid
//   if_ready            decode accepts the head entry
//   if_pc, if_instr     PC and instruction word of the head entry
// ---------------------------------------------------------------------------
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        icache_req_valid,
    output logic [31:0] icache_req_addr,
    input  logic        icache_req_ready,
    input  logic        icache_resp_valid,
    input  logic [31:0] icache_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    localparam int PTR_W = $clog2(FQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FQ_FULL = CNT_W'(FQ_DEPTH);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_MISS  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        target_q, target_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        fq_pc_q    [FQ_DEPTH];
    logic [31:0]        fq_pc_d    [FQ_DEPTH];
    logic [31:0]        fq_instr_q [FQ_DEPTH];
    logic [31:0]        fq_instr_d [FQ_DEPTH];

    logic        completion;
    logic        miss_launch;
    logic        push;
    logic        pop;
    logic [31:0] redirect_aligned;

    assign redirect_aligned = {redirect_pc[31:2], 2'b00};

    // The address is always the pc register; in MISS and DRAIN the pc is not
    // updated until completion, which keeps the address locked for the I-cache.
    assign icache_req_addr = pc_q;

    assign completion  = icache_req_valid & icache_resp_valid;
    assign miss_launch = (state_q == ST_FETCH) & icache_req_valid &
                         icache_req_ready & ~icache_resp_valid;

    // Request generation. Only registered state is used in FETCH, so there is
    // no combinational path from if_ready to the request.
    always_comb begin
        icache_req_valid = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_FETCH: icache_req_valid = (count_q < FQ_FULL);
                default:  icache_req_valid = 1'b1;
            endcase
        end
    end

    // Next-state logic for the fetch FSM, the pc and the pending redirect
    // target. A redirect always wins over a push in the same cycle.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        target_d = target_q;
        push     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (redirect_valid) begin
                    if (miss_launch) begin
                        target_d = redirect_aligned;
                        state_d  = ST_DRAIN;
                    end else begin
                        pc_d = redirect_aligned;
                    end
                end else if (completion) begin
                    push = 1'b1;
                    pc_d = pc_q + 32'd4;
                end else if (miss_launch) begin
                    state_d = ST_MISS;
                end
            end
            ST_MISS: begin
                if (redirect_valid) begin
                    if (completion) begin
                        pc_d    = redirect_aligned;
                        state_d = ST_FETCH;
                    end else begin
                        target_d = redirect_aligned;
                        state_d  = ST_DRAIN;
                    end
                end else if (completion) begin
                    push    = 1'b1;
                    pc_d    = pc_q + 32'd4;
                    state_d = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                // The stale response is always dropped. A redirect landing in
                // the same cycle as the drain completion jumps straight to the
                // newest target rather than re-issuing the stale address.
                if (redirect_valid) begin
                    target_d = redirect_aligned;
                    if (completion) begin
                        pc_d    = redirect_aligned;
                        state_d = ST_FETCH;
                    end
                end else if (completion) begin
                    pc_d    = target_q;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Fetch queue bookkeeping. A redirect flushes the queue and any pop in
    // that cycle is ignored.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        fq_pc_d    = fq_pc_q;
        fq_instr_d = fq_instr_q;
        pop        = if_valid & if_ready & ~redirect_valid;
        if (redirect_valid) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                fq_pc_d[wr_ptr_q]    = pc_q;
                fq_instr_d[wr_ptr_q] = icache_resp_data;
                wr_ptr_d             = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    assign if_valid = (count_q != '0);
    assign if_pc    = fq_pc_q[rd_ptr_q];
    assign if_instr = fq_instr_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_FETCH;
            pc_q     <= RESET_PC;
            target_q <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Queue storage carries no reset; the count guards its validity.
    always_ff @(posedge clk) begin
        fq_pc_q    <= fq_pc_d;
        fq_instr_q <= fq_instr_d;
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// ---------------------------------------------------------------------------
// tb_ifetch_unit
//
// Directed bench for ifetch_unit (RESET_PC=0x100, FQ_DEPTH=4). The I-cache
// is modelled as a same-cycle responder: hit_in drives icache_resp_valid and
// the returned word is the request address XOR a fixed pattern, so every
// queue entry's instruction is predictable from its PC.
// ---------------------------------------------------------------------------
module tb_ifetch_unit;

    localparam logic [31:0] INSTR_XOR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        icache_req_valid;
    logic [31:0] icache_req_addr;
    logic        icache_req_ready = 1'b0;
    logic        icache_resp_valid;
    logic [31:0] icache_resp_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        hit_in = 1'b0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        rst;
        logic        hit;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        ifr;
        logic        exp_req_valid;
        logic [31:0] exp_req_addr;
        logic        exp_if_valid;
        logic [31:0] exp_if_pc;
    } vec_t;

    vec_t tbl[$];

    ifetch_unit #(
        .RESET_PC(32'h0000_0100),
        .FQ_DEPTH(4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .icache_req_valid (icache_req_valid),
        .icache_req_addr  (icache_req_addr),
        .icache_req_ready (icache_req_ready),
        .icache_resp_valid(icache_resp_valid),
        .icache_resp_data (icache_resp_data),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .if_valid         (if_valid),
        .if_ready         (if_ready),
        .if_pc            (if_pc),
        .if_instr         (if_instr)
    );

    // Same-cycle I-cache model.
    assign icache_resp_valid = hit_in;
    assign icache_resp_data  = icache_req_addr ^ INSTR_XOR;

    always #5 clk = ~clk;

    // Drives one cycle of inputs on the falling edge, then lets combinational
    // outputs settle so they can be sampled well away from the rising edge.
    task automatic applyStimulus(input logic rst, input logic hit, input logic rdy,
                                 input logic rv, input logic [31:0] rpc, input logic ifr);
        @(negedge clk);
        reset            = rst;
        hit_in           = hit;
        icache_req_ready = rdy;
        redirect_valid   = rv;
        redirect_pc      = rpc;
        if_ready         = ifr;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Compares the outputs of one cycle; address and head contents are only
    // meaningful when the matching valid is expected high.
    task automatic checkCycle(input string tag, input logic erv, input logic [31:0] eaddr,
                              input logic eiv, input logic [31:0] epc);
        checkOutput({tag, "_req_valid"}, {31'b0, icache_req_valid}, {31'b0, erv});
        if (erv) checkOutput({tag, "_req_addr"}, icache_req_addr, eaddr);
        checkOutput({tag, "_if_valid"}, {31'b0, if_valid}, {31'b0, eiv});
        if (eiv) begin
            checkOutput({tag, "_if_pc"}, if_pc, epc);
            checkOutput({tag, "_if_instr"}, if_instr, epc ^ INSTR_XOR);
        end
    endtask

    function automatic void add(input logic rst, input logic hit, input logic rdy,
                                input logic rv, input logic [31:0] rpc, input logic ifr,
                                input logic erv, input logic [31:0] eaddr,
                                input logic eiv, input logic [31:0] epc);
        vec_t v;
        v.rst = rst; v.hit = hit; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.ifr = ifr;
        v.exp_req_valid = erv; v.exp_req_addr = eaddr;
        v.exp_if_valid = eiv; v.exp_if_pc = epc;
        tbl.push_back(v);
    endfunction

    initial begin
        // Columns: rst hit rdy rv rpc ifr | req_valid req_addr if_valid if_pc
        // Consecutive hits with decode always ready.
        add(1, 1, 1, 0, 32'h0, 1,  0, 32'h0,        0, 32'h0);
        add(0, 1, 1, 0, 32'h0, 1,  1, 32'h100,      0, 32'h0);
        add(0, 1, 1, 0, 32'h0, 1,  1, 32'h104,      1, 32'h100);
        add(0, 1, 1, 0, 32'h0, 1,  1, 32'h108,      1, 32'h104);
        // Miss at 0x100 held for five cycles, then one push.
        add(1, 0, 1, 0, 32'h0, 0,  0, 32'h0,        1, 32'h108);
        add(0, 0, 1, 0, 32'h0, 1,  1, 32'h100,      0, 32'h0);
        add(0, 0, 0, 0, 32'h0, 1,  1, 32'h100,      0, 32'h0);
        add(0, 0, 0, 0, 32'h0, 1,  1, 32'h100,      0, 32'h0);
        add(0, 0, 0, 0, 32'h0, 1,  1, 32'h100,      0, 32'h0);
        add(0, 0, 0, 0, 32'h0, 1,  1, 32'h100,      0, 32'h0);
        add(0, 1, 0, 0, 32'h0, 1,  1, 32'h100,      0, 32'h0);
        add(0, 0, 0, 0, 32'h0, 0,  1, 32'h104,      1, 32'h100);
        add(0, 0, 0, 0, 32'h0, 1,  1, 32'h104,      1, 32'h100);
        add(0, 0, 0, 0, 32'h0, 1,  1, 32'h104,      0, 32'h0);
        // Backpressure fills the queue, then drains in order.
        add(1, 1, 1, 0, 32'h0, 0,  0, 32'h0,        0, 32'h0);
        add(0, 1, 1, 0, 32'h0, 0,  1, 32'h100,      0, 32'h0);
        add(0, 1, 1, 0, 32'h0, 0,  1, 32'h104,      1, 32'h100);
        add(0, 1, 1, 0, 32'h0, 0,  1, 32'h108,      1, 32'h100);
        add(0, 1, 1, 0, 32'h0, 0,  1, 32'h10C,      1, 32'h100);
        add(0, 1, 1, 0, 32'h0, 0,  0, 32'h0,        1, 32'h100);
        add(0, 1, 1, 0, 32'h0, 0,  0, 32'h0,        1, 32'h100);
        add(0, 1, 1, 0, 32'h0, 1,  0, 32'h0,        1, 32'h100);
        add(0, 1, 1, 0, 32'h0, 1,  1, 32'h110,      1, 32'h104);
        add(0, 1, 1, 0, 32'h0, 1,  1, 32'h114,      1, 32'h108);
        add(0, 1, 1, 0, 32'h0, 1,  1, 32'h118,      1, 32'h10C);
        add(0, 1, 1, 0, 32'h0, 1,  1, 32'h11C,      1, 32'h110);
        // Redirect two cycles into a miss: drain, drop data, go to 0x2000.
        add(1, 0, 1, 0, 32'h0, 1,  0, 32'h0,        1, 32'h114);
        add(0, 0, 1, 0, 32'h0, 1,  1, 32'h100,      0, 32'h0);
        add(0, 0, 0, 0, 32'h0, 1,  1, 32'h100,      0, 32'h0);
        add(0, 0, 0, 1, 32'h2003, 1, 1, 32'h100,    0, 32'h0);
        add(0, 0, 0, 0, 32'h0, 1,  1, 32'h100,      0, 32'h0);
        add(0, 1, 0, 0, 32'h0, 1,  1, 32'h100,      0, 32'h0);
        add(0, 0, 0, 0, 32'h0, 1,  1, 32'h2000,     0, 32'h0);
        // Two queued entries, redirect on a hit cycle with decode ready.
        add(0, 1, 1, 0, 32'h0, 0,  1, 32'h2000,     0, 32'h0);
        add(0, 1, 1, 0, 32'h0, 0,  1, 32'h2004,     1, 32'h2000);
        add(0, 1, 1, 1, 32'h3000, 1, 1, 32'h2008,   1, 32'h2000);
        add(0, 0, 0, 0, 32'h0, 1,  1, 32'h3000,     0, 32'h0);
        // PC wrap at the top of the address space, then reset mid-miss.
        add(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 1, 32'h3000, 0, 32'h0);
        add(0, 1, 1, 0, 32'h0, 0,  1, 32'hFFFF_FFFC, 0, 32'h0);
        add(0, 1, 1, 0, 32'h0, 0,  1, 32'h0000_0000, 1, 32'hFFFF_FFFC);
        add(0, 0, 1, 0, 32'h0, 0,  1, 32'h0000_0004, 1, 32'hFFFF_FFFC);
        add(1, 0, 0, 0, 32'h0, 0,  0, 32'h0,        1, 32'hFFFF_FFFC);
        add(0, 0, 0, 0, 32'h0, 0,  1, 32'h100,      0, 32'h0);

        $display("[TB] starting, %0d table rows", tbl.size());
        applyStimulus(1, 0, 0, 0, 32'h0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].rst, tbl[i].hit, tbl[i].rdy, tbl[i].rv, tbl[i].rpc, tbl[i].ifr);
            checkCycle($sformatf("row%0d", i), tbl[i].exp_req_valid, tbl[i].exp_req_addr,
                       tbl[i].exp_if_valid, tbl[i].exp_if_pc);
        end

        // Reset and redirect together: reset wins.
        applyStimulus(1, 0, 0, 1, 32'h5000, 0);
        applyStimulus(0, 0, 0, 0, 32'h0, 0);
        checkCycle("rst_vs_redirect", 1'b1, 32'h100, 1'b0, 32'h0);

        // Redirect on the miss-launch cycle, overwritten by a newer redirect
        // while draining; the newest target is fetched after completion.
        applyStimulus(0, 0, 1, 1, 32'h4000, 0);
        checkCycle("launch_redirect", 1'b1, 32'h100, 1'b0, 32'h0);
        applyStimulus(0, 0, 0, 1, 32'h6006, 0);
        checkCycle("drain_redirect", 1'b1, 32'h100, 1'b0, 32'h0);
        applyStimulus(0, 1, 0, 0, 32'h0, 0);
        checkCycle("drain_complete", 1'b1, 32'h100, 1'b0, 32'h0);
        applyStimulus(0, 0, 0, 0, 32'h0, 0);
        checkCycle("after_drain", 1'b1, 32'h6004, 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction fetch stage sitting directly upstream of the instruction cache. Owns the program counter and issues one 32-bit aligned fetch request at a time to the I-cache. Buffers returned instructions with their PC in a small FIFO that feeds decode. Handles control-flow redirects, including a redirect that arrives while a cache miss is still being serviced.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
FQ_DEPTH, 4, fetch-queue entries; must be a power of 2 and at least 2.

Ports:
clk  input  1  clock; all state updates on its rising edge.
reset  input  1  synchronous reset, active-high.
icache_req_valid  output  1  fetch request to the I-cache.
icache_req_addr  output  32  fetch address; bits [1:0] always 0.
icache_req_ready  input  1  I-cache idle; can start a new lookup.
icache_resp_valid  input  1  I-cache hit/data valid (same-cycle, combinational on the address).
icache_resp_data  input  32  instruction word.
redirect_valid  input  1  branch/jump/trap redirect.
redirect_pc  input  32  redirect target; bits [1:0] ignored and treated as 0.
if_valid  output  1  head of fetch queue valid.
if_ready  input  1  decode accepts the head entry.
if_pc  output  32  PC of the head entry.
if_instr  output  32  instruction of the head entry.

Behaviour:
- Reset, while reset=1 and on the following edge:
  - state=FETCH, pc=RESET_PC, queue empty.
  - icache_req_valid=0 while reset is high.
  - if_valid=0.
  - if_pc and if_instr are don't-care.
- Transaction completion: a request completes in any cycle with icache_req_valid=1 and icache_resp_valid=1. icache_req_addr must stay stable from first assertion until completion.
- Miss launch: a cycle with icache_req_valid=1, icache_req_ready=1 and icache_resp_valid=0. From then on the address is locked until completion.
- State FETCH:
  - icache_req_valid = (count < FQ_DEPTH), with icache_req_addr = pc.
  - No combinational path from if_ready to icache_req_valid.
  - On completion: push {pc, resp_data} and set pc <= pc+4. pc+4 wraps modulo 2^32.
  - On miss launch: go to MISS.
- State MISS:
  - icache_req_valid=1, address held at pc.
  - On completion: push the entry, pc <= pc+4, go to FETCH.
- State DRAIN:
  - icache_req_valid=1, address held at the old pc.
  - On completion: discard the data, pc <= target, go to FETCH.
- Redirect (redirect_valid=1); redirect overrides any push in the same cycle:
  - The queue is flushed that cycle and any pop in that cycle is ignored.
  - FETCH without miss launch, or MISS with completion: pc <= redirect_pc&~3, stay in or go to FETCH.
  - FETCH with miss launch, or MISS without completion: target <= redirect_pc&~3, go to DRAIN.
  - DRAIN: target overwritten with the newest redirect; stay in DRAIN.
- Fetch queue:
  - FIFO with wrapping read and write pointers plus a count of width log2(FQ_DEPTH)+1.
  - if_valid = (count != 0); if_pc and if_instr come from the head entry (registered storage).
  - Pop when if_valid && if_ready; push and pop in the same cycle keeps count unchanged.
  - A push while full cannot occur, because requests are only issued when count < FQ_DEPTH.
  - Throughput is one instruction per cycle on consecutive hits.
- Latency: an instruction that hits at cycle N is visible on if_valid at cycle N+1.
- Simultaneous reset and redirect: reset wins.
- Reset mid-miss: the block returns to FETCH immediately. The I-cache is reset in the same cycle by system convention.

Test Plan:
1. RESET_PC=0x100, cache always hits, if_ready=1 -> request addresses 0x100, 0x104, 0x108 on consecutive cycles; if_valid first rises one cycle after the first hit with if_pc=0x100.
2. Miss at 0x100, resp_valid held low for 5 cycles -> icache_req_addr stays 0x100 and icache_req_valid stays 1 throughout; exactly one push; next request is 0x104.
3. if_ready=0 with all hits, FQ_DEPTH=4 -> 4 pushes, then icache_req_valid=0 with pc=0x110 held; raise if_ready -> entries 0x100..0x10C pop in order and fetch resumes at 0x110.
4. Redirect to 0x2003 two cycles into a miss at 0x100 -> address stays 0x100 until the response, data is dropped, queue is empty, next request is 0x2000.
5. Queue holds 2 entries; redirect to 0x3000 on a hit cycle with if_ready=1 -> queue empty next cycle, no push of the hit data, next request is 0x3000.
6. Redirect to 0xFFFFFFFC, then two hits -> requests 0xFFFFFFFC then 0x00000000; reset asserted mid-miss -> next request is RESET_PC with the queue empty.
